// File: rtl/framebuffer_vram_dbuf_if.sv
// Pixel-write, scanout-read and status bundle for the double-buffered framebuffer.
// Widths derive from the frame geometry so both ends agree by construction.
interface framebuffer_vram_dbuf_if #(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240,
  parameter int DW     = 8
);
  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);

  logic          wr_valid;
  logic          wr_sof;
  logic [DW-1:0] wr_data;
  logic          rd_frame_start;
  logic          rd_en;
  logic [XW-1:0] rd_x;
  logic [YW-1:0] rd_y;
  logic [DW-1:0] rd_q;
  logic          rd_valid;
  logic          disp_bank;
  logic          frame_pending;
  logic [7:0]    drop_cnt;

  modport master (
    output wr_valid, wr_sof, wr_data, rd_frame_start, rd_en, rd_x, rd_y,
    input  rd_q, rd_valid, disp_bank, frame_pending, drop_cnt
  );

  modport slave (
    input  wr_valid, wr_sof, wr_data, rd_frame_start, rd_en, rd_x, rd_y,
    output rd_q, rd_valid, disp_bank, frame_pending, drop_cnt
  );
endinterface

// File: rtl/framebuffer_vram_dbuf.sv
// Two-bank framebuffer: raster writes fill the back bank, scanout reads the display
// bank by (x,y); banks swap only at a scanout frame boundary once a full frame is in.
module framebuffer_vram_dbuf #(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240,
  parameter int DW     = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  framebuffer_vram_dbuf_if.slave bus
);
  localparam int N  = WIDTH * HEIGHT;
  localparam int AW = $clog2(N);
  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam int IW = AW + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;
  localparam logic [1:0] S_SKIP  = 2'd3;

  logic [DW-1:0] mem [0:2*N-1];

  logic [1:0]    state, state_nx;
  logic [AW-1:0] wr_cnt, wr_cnt_nx;
  logic [AW-1:0] waddr;
  logic          disp_bank, frame_pending;
  logic [7:0]    drop_cnt;
  logic          sof_px, px, swap, we, wbank, drop_inc, pend_set;
  logic [IW-1:0] widx;

  assign sof_px = bus.wr_valid & bus.wr_sof;
  assign px     = bus.wr_valid & ~bus.wr_sof;

  always_comb begin
    state_nx  = state;
    wr_cnt_nx = wr_cnt;
    waddr     = wr_cnt;
    we        = 1'b0;
    swap      = 1'b0;
    drop_inc  = 1'b0;
    pend_set  = 1'b0;
    case (state)
      S_IDLE: if (sof_px) begin
        we        = 1'b1;
        waddr     = '0;
        wr_cnt_nx = AW'(1);
        state_nx  = S_WRITE;
      end
      S_WRITE: if (sof_px) begin
        // a new sof mid-frame restarts the frame; the partial one counts as dropped
        drop_inc  = 1'b1;
        we        = 1'b1;
        waddr     = '0;
        wr_cnt_nx = AW'(1);
      end else if (px) begin
        we        = 1'b1;
        wr_cnt_nx = wr_cnt + AW'(1);
        if (wr_cnt == AW'(N - 1)) begin
          state_nx = S_FULL;
          pend_set = 1'b1;
        end
      end
      default: if (bus.rd_frame_start) begin
        swap = 1'b1;
        if (sof_px) begin
          we        = 1'b1;
          waddr     = '0;
          wr_cnt_nx = AW'(1);
          state_nx  = S_WRITE;
        end else begin
          state_nx  = S_IDLE;
        end
      end else if (state == S_FULL && sof_px) begin
        drop_inc = 1'b1;
        state_nx = S_SKIP;
      end
    endcase
  end

  // during a swap the back bank becomes the bank that was just displayed
  assign wbank = swap ? disp_bank : ~disp_bank;
  assign widx  = wbank ? IW'(N) + IW'(waddr) : IW'(waddr);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      wr_cnt        <= '0;
      disp_bank     <= 1'b0;
      frame_pending <= 1'b0;
      drop_cnt      <= '0;
    end else begin
      state  <= state_nx;
      wr_cnt <= wr_cnt_nx;
      if (swap) begin
        disp_bank     <= ~disp_bank;
        frame_pending <= 1'b0;
      end else if (pend_set) begin
        frame_pending <= 1'b1;
      end
      if (drop_inc && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[widx] <= bus.wr_data;
  end

  // read pipeline: stage 1 latches bank/address, stage 2 reads the array
  logic [1:0]    vld_pipe;
  logic          s1_bank, s1_inr;
  logic [AW-1:0] s1_addr;
  logic [DW-1:0] rd_q;
  logic          in_range;
  logic [AW-1:0] raddr;
  logic [IW-1:0] ridx;

  assign in_range = ({1'b0, bus.rd_x} < (XW+1)'(WIDTH)) &&
                    ({1'b0, bus.rd_y} < (YW+1)'(HEIGHT));
  assign raddr    = AW'(bus.rd_y) * AW'(WIDTH) + AW'(bus.rd_x);
  assign ridx     = s1_bank ? IW'(N) + IW'(s1_addr) : IW'(s1_addr);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe <= '0;
      s1_bank  <= 1'b0;
      s1_inr   <= 1'b0;
      s1_addr  <= '0;
      rd_q     <= '0;
    end else begin
      vld_pipe <= {vld_pipe[0], bus.rd_en};
      s1_bank  <= disp_bank;
      s1_inr   <= in_range;
      s1_addr  <= raddr;
      if (vld_pipe[0]) rd_q <= s1_inr ? mem[ridx] : '0;
    end
  end

  assign bus.rd_q          = rd_q;
  assign bus.rd_valid      = vld_pipe[1];
  assign bus.disp_bank     = disp_bank;
  assign bus.frame_pending = frame_pending;
  assign bus.drop_cnt      = drop_cnt;
endmodule

// File: tb/tb_framebuffer_vram_dbuf.sv
// Scenario bench for framebuffer_vram_dbuf: 4x2 main instance with a read scoreboard,
// plus a 3x3 instance whose non-power-of-two geometry exposes out-of-range coordinates.
module tb_framebuffer_vram_dbuf;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  framebuffer_vram_dbuf_if #(.WIDTH(4), .HEIGHT(2), .DW(8)) bus ();
  framebuffer_vram_dbuf_if #(.WIDTH(3), .HEIGHT(3), .DW(8)) bus2 ();

  framebuffer_vram_dbuf #(.WIDTH(4), .HEIGHT(2), .DW(8)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus));
  framebuffer_vram_dbuf #(.WIDTH(3), .HEIGHT(3), .DW(8)) dut2 (
    .clk(clk), .reset_n(reset_n), .bus(bus2));

  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];

  // scoreboard: every valid read on the main instance pops one expectation
  always @(negedge clk) begin
    if (reset_n && bus.rd_valid) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL rd_unexpected: got %h with nothing expected", bus.rd_q);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (bus.rd_q !== e) begin
          bad++;
          $display("FAIL rd_data: got %h expected %h", bus.rd_q, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_px(input logic sof, input logic [7:0] d);
    bus.wr_valid = 1'b1;
    bus.wr_sof   = sof;
    bus.wr_data  = d;
    tick();
    bus.wr_valid = 1'b0;
    bus.wr_sof   = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] base);
    for (int i = 0; i < 8; i++) send_px(i == 0, 8'(base + 8'(i)));
  endtask

  task automatic swap();
    bus.rd_frame_start = 1'b1;
    tick();
    bus.rd_frame_start = 1'b0;
  endtask

  task automatic rd_req(input int x, input int y, input logic [7:0] e);
    bus.rd_en = 1'b1;
    bus.rd_x  = x[1:0];
    bus.rd_y  = y[0:0];
    exp_q.push_back(e);
    tick();
    bus.rd_en = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 8) begin
      tick();
      n++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL rd_drain: got %0d reads outstanding expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    send_frame(8'h10);
    swap();
    send_frame(8'h80);
    send_px(1'b1, 8'h90);
    total++;
    if ({bus.disp_bank, bus.frame_pending, bus.drop_cnt} !== {1'b1, 1'b1, 8'd1}) begin
      bad++;
      $display("FAIL pre_reset_state: got %b/%b/%0d expected 1/1/1",
               bus.disp_bank, bus.frame_pending, bus.drop_cnt);
    end
    bus.rd_en = 1'b1; bus.rd_x = 2'd0; bus.rd_y = 1'b0;
    tick();
    bus.rd_en = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    exp_q.delete();
    total++; if (bus.rd_q !== 8'h00) begin bad++; $display("FAIL rst_rd_q: got %h expected 00", bus.rd_q); end
    total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL rst_rd_valid: got %b expected 0", bus.rd_valid); end
    total++; if (bus.disp_bank !== 1'b0) begin bad++; $display("FAIL rst_disp_bank: got %b expected 0", bus.disp_bank); end
    total++; if (bus.frame_pending !== 1'b0) begin bad++; $display("FAIL rst_pending: got %b expected 0", bus.frame_pending); end
    total++; if (bus.drop_cnt !== 8'd0) begin bad++; $display("FAIL rst_drop: got %0d expected 0", bus.drop_cnt); end
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (3) tick();
    total++;
    if ({bus.rd_q, bus.rd_valid, bus.disp_bank, bus.frame_pending, bus.drop_cnt} !== 19'd0) begin
      bad++;
      $display("FAIL post_release: got %h/%b/%b/%b/%0d expected all 0", bus.rd_q,
               bus.rd_valid, bus.disp_bank, bus.frame_pending, bus.drop_cnt);
    end
  endtask

  task automatic test_write_swap();
    for (int i = 0; i < 7; i++) send_px(i == 0, 8'(8'h10 + 8'(i)));
    total++; if (bus.frame_pending !== 1'b0) begin bad++; $display("FAIL pending_early: got %b expected 0", bus.frame_pending); end
    send_px(1'b0, 8'h17);
    total++; if (bus.frame_pending !== 1'b1) begin bad++; $display("FAIL pending_set: got %b expected 1", bus.frame_pending); end
    swap();
    total++; if (bus.disp_bank !== 1'b1) begin bad++; $display("FAIL swap_bank: got %b expected 1", bus.disp_bank); end
    total++; if (bus.frame_pending !== 1'b0) begin bad++; $display("FAIL swap_pending: got %b expected 0", bus.frame_pending); end
    // single read: nothing after one edge, data after the second
    rd_req(3, 1, 8'h17);
    total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL lat_early: got %b expected 0", bus.rd_valid); end
    tick();
    total++; if (bus.rd_valid !== 1'b1) begin bad++; $display("FAIL lat_valid: got %b expected 1", bus.rd_valid); end
    tick();
    rd_req(0, 0, 8'h10);
    drain();
  endtask

  task automatic test_drop_full();
    send_frame(8'h10);
    send_frame(8'h20);
    total++; if (bus.drop_cnt !== 8'd1) begin bad++; $display("FAIL drop_full: got %0d expected 1", bus.drop_cnt); end
    total++; if (bus.frame_pending !== 1'b1) begin bad++; $display("FAIL skip_pending: got %b expected 1", bus.frame_pending); end
    swap();
    total++; if (bus.disp_bank !== 1'b0) begin bad++; $display("FAIL drop_swap_bank: got %b expected 0", bus.disp_bank); end
    for (int i = 0; i < 8; i++) rd_req(i % 4, i / 4, 8'(8'h10 + 8'(i)));
    drain();
  endtask

  task automatic test_abort();
    send_px(1'b1, 8'h30);
    send_px(1'b0, 8'h31);
    send_px(1'b0, 8'h32);
    send_px(1'b1, 8'h40);
    total++; if (bus.drop_cnt !== 8'd2) begin bad++; $display("FAIL drop_abort: got %0d expected 2", bus.drop_cnt); end
    for (int i = 1; i < 8; i++) send_px(1'b0, 8'(8'h40 + 8'(i)));
    total++; if (bus.frame_pending !== 1'b1) begin bad++; $display("FAIL abort_pending: got %b expected 1", bus.frame_pending); end
    // display bank still shows the previous frame until the swap
    rd_req(0, 0, 8'h10);
    drain();
    swap();
    rd_req(0, 0, 8'h40);
    rd_req(1, 0, 8'h41);
    rd_req(3, 1, 8'h47);
    drain();
  endtask

  task automatic test_range_back_to_back();
    for (int i = 0; i < 9; i++) begin
      bus2.wr_valid = 1'b1;
      bus2.wr_sof   = (i == 0);
      bus2.wr_data  = 8'(8'hA0 + 8'(i));
      tick();
    end
    bus2.wr_valid = 1'b0;
    bus2.wr_sof   = 1'b0;
    total++; if (bus2.frame_pending !== 1'b1) begin bad++; $display("FAIL r_pending: got %b expected 1", bus2.frame_pending); end
    bus2.rd_frame_start = 1'b1;
    tick();
    bus2.rd_frame_start = 1'b0;
    bus2.rd_en = 1'b1; bus2.rd_x = 2'd3; bus2.rd_y = 2'd0;
    tick();
    bus2.rd_x = 2'd0; bus2.rd_y = 2'd3;
    tick();
    bus2.rd_x = 2'd2; bus2.rd_y = 2'd2;
    total++;
    if ({bus2.rd_valid, bus2.rd_q} !== {1'b1, 8'h00}) begin
      bad++; $display("FAIL oor_x: got %b/%h expected 1/00", bus2.rd_valid, bus2.rd_q);
    end
    tick();
    bus2.rd_en = 1'b0;
    total++;
    if ({bus2.rd_valid, bus2.rd_q} !== {1'b1, 8'h00}) begin
      bad++; $display("FAIL oor_y: got %b/%h expected 1/00", bus2.rd_valid, bus2.rd_q);
    end
    tick();
    total++;
    if ({bus2.rd_valid, bus2.rd_q} !== {1'b1, 8'hA8}) begin
      bad++; $display("FAIL in_range_corner: got %b/%h expected 1/a8", bus2.rd_valid, bus2.rd_q);
    end
    // three back-to-back reads on the main instance give three consecutive valids
    bus.rd_en = 1'b1;
    bus.rd_y  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.rd_x = 2'(i);
      exp_q.push_back(8'(8'h40 + 8'(i)));
      tick();
      if (i > 0) begin
        total++; if (bus.rd_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid%0d: got %b expected 1", i, bus.rd_valid); end
      end
    end
    bus.rd_en = 1'b0;
    tick();
    total++; if (bus.rd_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid3: got %b expected 1", bus.rd_valid); end
    tick();
    total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL b2b_idle: got %b expected 0", bus.rd_valid); end
    drain();
  endtask

  task automatic test_swap_sof_saturate();
    send_frame(8'h60);
    // swap, sof pixel and a read of the old display bank all in one cycle
    bus.rd_frame_start = 1'b1;
    bus.wr_valid = 1'b1; bus.wr_sof = 1'b1; bus.wr_data = 8'h70;
    bus.rd_en = 1'b1; bus.rd_x = 2'd3; bus.rd_y = 1'b1;
    exp_q.push_back(8'h47);
    tick();
    bus.rd_frame_start = 1'b0;
    bus.wr_valid = 1'b0; bus.wr_sof = 1'b0; bus.rd_en = 1'b0;
    total++; if (bus.disp_bank !== 1'b0) begin bad++; $display("FAIL ss_bank: got %b expected 0", bus.disp_bank); end
    total++; if (bus.drop_cnt !== 8'd2) begin bad++; $display("FAIL ss_drop: got %0d expected 2", bus.drop_cnt); end
    for (int i = 1; i < 8; i++) send_px(1'b0, 8'(8'h70 + 8'(i)));
    total++; if (bus.frame_pending !== 1'b1) begin bad++; $display("FAIL ss_write_state: got %b expected 1", bus.frame_pending); end
    drain();
    swap();
    total++; if (bus.disp_bank !== 1'b1) begin bad++; $display("FAIL ss_swap2: got %b expected 1", bus.disp_bank); end
    rd_req(0, 0, 8'h70);
    rd_req(3, 1, 8'h77);
    drain();
    // one sof enters WRITE, each further sof is a dropped frame
    send_px(1'b1, 8'h00);
    for (int i = 0; i < 252; i++) send_px(1'b1, 8'h00);
    total++; if (bus.drop_cnt !== 8'd254) begin bad++; $display("FAIL drop_254: got %0d expected 254", bus.drop_cnt); end
    send_px(1'b1, 8'h00);
    total++; if (bus.drop_cnt !== 8'd255) begin bad++; $display("FAIL drop_255: got %0d expected 255", bus.drop_cnt); end
    for (int i = 0; i < 47; i++) send_px(1'b1, 8'h00);
    total++; if (bus.drop_cnt !== 8'd255) begin bad++; $display("FAIL drop_sat: got %0d expected 255", bus.drop_cnt); end
  endtask

  initial begin
    bus.wr_valid = 1'b0; bus.wr_sof = 1'b0; bus.wr_data = '0;
    bus.rd_frame_start = 1'b0; bus.rd_en = 1'b0; bus.rd_x = '0; bus.rd_y = '0;
    bus2.wr_valid = 1'b0; bus2.wr_sof = 1'b0; bus2.wr_data = '0;
    bus2.rd_frame_start = 1'b0; bus2.rd_en = 1'b0; bus2.rd_x = '0; bus2.rd_y = '0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    test_reset();
    test_write_swap();
    test_drop_full();
    test_abort();
    test_range_back_to_back();
    test_swap_sof_saturate();
    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
